// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared frame counter and double-buffered period/duty
module pwm_multi #(
    parameter int CH = 4,
    parameter int CW = 8
) (
    input  logic             clk1ms,
    input  logic             reset,
    input  logic             enable,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    input  logic             load,
    input  logic [CH-1:0]    invert,
    output logic [CH-1:0]    pwm,
    output logic [1:0]       state,
    output logic [CW-1:0]    counter,
    output logic             frame_done,
    output logic             pending
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t             st, st_n;
    logic [CW-1:0]      cnt_n;
    logic [CW-1:0]      sh_period, act_period;
    logic [CH*CW-1:0]   sh_duty, act_duty;
    logic               boundary;

    assign state      = st;
    assign frame_done = (st != IDLE) && (counter == act_period);
    // Frame boundaries are where new active values may be applied without a runt pulse.
    assign boundary   = frame_done || ((st == IDLE) && enable);

    always_comb begin
        st_n  = st;
        cnt_n = counter;
        case (st)
            IDLE: begin
                cnt_n = '0;
                if (enable) st_n = RUN;
            end
            RUN: begin
                if (frame_done) begin
                    cnt_n = '0;
                    st_n  = enable ? RUN : IDLE;
                end else begin
                    cnt_n = counter + CW'(1);
                    if (!enable) st_n = STOP;
                end
            end
            STOP: begin
                if (frame_done) begin
                    cnt_n = '0;
                    st_n  = IDLE;
                end else begin
                    cnt_n = counter + CW'(1);
                    if (enable) st_n = RUN;
                end
            end
            default: begin
                cnt_n = '0;
                st_n  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1ms or negedge reset) begin
        if (!reset) begin
            st      <= IDLE;
            counter <= '0;
        end else begin
            st      <= st_n;
            counter <= cnt_n;
        end
    end

    always_ff @(posedge clk1ms or negedge reset) begin
        if (!reset) begin
            sh_period  <= '0;
            sh_duty    <= '0;
            act_period <= '0;
            act_duty   <= '0;
            pending    <= 1'b0;
        end else if (boundary) begin
            pending <= 1'b0;
            // A load coinciding with the boundary wins over any older shadow contents.
            if (load) begin
                act_period <= period;
                act_duty   <= duty;
            end else if (pending) begin
                act_period <= sh_period;
                act_duty   <= sh_duty;
            end
        end else if (load) begin
            sh_period <= period;
            sh_duty   <= duty;
            pending   <= 1'b1;
        end
    end

    always_comb begin
        pwm = invert;
        for (int i = 0; i < CH; i++) begin
            pwm[i] = invert[i] ^ ((st != IDLE) && (counter < act_duty[i*CW +: CW]));
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi with directed frame scenarios
module tb_pwm_multi;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b10;

    logic        clk1ms;
    logic        reset;
    logic        enable;
    logic [7:0]  period;
    logic [31:0] duty;
    logic        load;
    logic [3:0]  invert;
    logic [3:0]  pwm;
    logic [1:0]  state;
    logic [7:0]  counter;
    logic        frame_done;
    logic        pending;

    typedef struct {
        logic [7:0] c;
        logic [1:0] s;
        logic       fd;
        logic       pd;
        logic [3:0] pw;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    pwm_multi #(.CH(4), .CW(8)) dut (
        .clk1ms     (clk1ms),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .duty       (duty),
        .load       (load),
        .invert     (invert),
        .pwm        (pwm),
        .state      (state),
        .counter    (counter),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial begin
        clk1ms = 1'b1;
        forever #5 clk1ms = ~clk1ms;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk1ms) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("counter",    counter,              e.c);
            chk("state",      {6'd0, state},        {6'd0, e.s});
            chk("frame_done", {7'd0, frame_done},   {7'd0, e.fd});
            chk("pending",    {7'd0, pending},      {7'd0, e.pd});
            chk("pwm",        {4'd0, pwm},          {4'd0, e.pw});
        end
    end

    function automatic logic [3:0] pwx(input int c, input int d3, input int d2,
                                       input int d1, input int d0, input logic [3:0] inv);
        logic [3:0] raw;
        raw = {logic'(c < d3), logic'(c < d2), logic'(c < d1), logic'(c < d0)};
        return inv ^ raw;
    endfunction

    task automatic tick();
        @(posedge clk1ms);
        #1;
    endtask

    task automatic cyc(input int c, input logic [1:0] s, input logic fd,
                       input logic pd, input logic [3:0] pw);
        exp_t e;
        e.c  = c[7:0];
        e.s  = s;
        e.fd = fd;
        e.pd = pd;
        e.pw = pw;
        q.push_back(e);
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        period = 8'd0;
        duty   = 32'd0;
        load   = 1'b0;
        invert = 4'b0101;
        cyc(0, S_IDLE, 0, 0, 4'b0101);
        cyc(0, S_IDLE, 0, 0, 4'b0101);
        reset  = 1'b1;
        invert = 4'b0000;

        // Basic duties: ch3=5, ch2=10 (>period), ch1=0, ch0=3 over a 10-cycle frame
        period = 8'd9;
        duty   = {8'd5, 8'd10, 8'd0, 8'd3};
        load   = 1'b1;
        cyc(0, S_IDLE, 0, 0, 4'b0000);
        load   = 1'b0;
        enable = 1'b1;
        cyc(0, S_IDLE, 0, 1, 4'b0000);
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < 10; c++)
                cyc(c, S_RUN, c == 9, 0, pwx(c, 5, 10, 0, 3, 4'b0000));

        // Polarity on ch3
        invert = 4'b1000;
        for (int c = 0; c < 10; c++)
            cyc(c, S_RUN, c == 9, 0, pwx(c, 5, 10, 0, 3, 4'b1000));

        // Mid-frame load of ch0 duty=7 at counter 4
        for (int c = 0; c < 4; c++)
            cyc(c, S_RUN, 0, 0, pwx(c, 5, 10, 0, 3, 4'b1000));
        duty = {8'd5, 8'd10, 8'd0, 8'd7};
        load = 1'b1;
        cyc(4, S_RUN, 0, 0, pwx(4, 5, 10, 0, 3, 4'b1000));
        load = 1'b0;
        for (int c = 5; c < 10; c++)
            cyc(c, S_RUN, c == 9, 1, pwx(c, 5, 10, 0, 3, 4'b1000));
        for (int c = 0; c < 10; c++)
            cyc(c, S_RUN, c == 9, 0, pwx(c, 5, 10, 0, 7, 4'b1000));

        // Load period=4 on the boundary cycle: applies directly, pending stays low
        for (int c = 0; c < 9; c++)
            cyc(c, S_RUN, 0, 0, pwx(c, 5, 10, 0, 7, 4'b1000));
        period = 8'd4;
        load   = 1'b1;
        cyc(9, S_RUN, 1, 0, pwx(9, 5, 10, 0, 7, 4'b1000));
        load   = 1'b0;
        for (int c = 0; c < 5; c++)
            cyc(c, S_RUN, c == 4, 0, 4'b0101);
        for (int c = 0; c < 4; c++)
            cyc(c, S_RUN, 0, 0, 4'b0101);
        period = 8'd9;
        load   = 1'b1;
        cyc(4, S_RUN, 1, 0, 4'b0101);
        load   = 1'b0;
        for (int c = 0; c < 10; c++)
            cyc(c, S_RUN, c == 9, 0, pwx(c, 5, 10, 0, 7, 4'b1000));

        // Stop at counter 5: frame completes in STOP, then IDLE with pwm=invert
        for (int c = 0; c < 5; c++)
            cyc(c, S_RUN, 0, 0, pwx(c, 5, 10, 0, 7, 4'b1000));
        enable = 1'b0;
        cyc(5, S_RUN, 0, 0, pwx(5, 5, 10, 0, 7, 4'b1000));
        for (int c = 6; c < 10; c++)
            cyc(c, S_STOP, c == 9, 0, pwx(c, 5, 10, 0, 7, 4'b1000));
        cyc(0, S_IDLE, 0, 0, 4'b1000);
        cyc(0, S_IDLE, 0, 0, 4'b1000);
        enable = 1'b1;
        cyc(0, S_IDLE, 0, 0, 4'b1000);

        // Stop at 5, resume at 7: frame continues unbroken
        for (int c = 0; c < 5; c++)
            cyc(c, S_RUN, 0, 0, pwx(c, 5, 10, 0, 7, 4'b1000));
        enable = 1'b0;
        cyc(5, S_RUN, 0, 0, pwx(5, 5, 10, 0, 7, 4'b1000));
        cyc(6, S_STOP, 0, 0, pwx(6, 5, 10, 0, 7, 4'b1000));
        enable = 1'b1;
        cyc(7, S_STOP, 0, 0, pwx(7, 5, 10, 0, 7, 4'b1000));
        cyc(8, S_RUN, 0, 0, pwx(8, 5, 10, 0, 7, 4'b1000));
        cyc(9, S_RUN, 1, 0, pwx(9, 5, 10, 0, 7, 4'b1000));

        // Async reset at counter 6 with a pending load
        for (int c = 0; c < 4; c++)
            cyc(c, S_RUN, 0, 0, pwx(c, 5, 10, 0, 7, 4'b1000));
        duty = {8'd5, 8'd10, 8'd0, 8'd2};
        load = 1'b1;
        cyc(4, S_RUN, 0, 0, pwx(4, 5, 10, 0, 7, 4'b1000));
        load = 1'b0;
        cyc(5, S_RUN, 0, 1, pwx(5, 5, 10, 0, 7, 4'b1000));
        reset = 1'b0;
        cyc(0, S_IDLE, 0, 0, 4'b1000);
        cyc(0, S_IDLE, 0, 0, 4'b1000);
        reset = 1'b1;
        cyc(0, S_IDLE, 0, 0, 4'b1000);
        // Active period and duty are 0: one-cycle frames, raw outputs low
        for (int k = 0; k < 4; k++)
            cyc(0, S_RUN, 1, 0, 4'b1000);

        for (int k = 0; k < 4 && q.size() > 0; k++)
            tick();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
